// File: rtl/iq_pkg.sv
// Shared definitions for the IQ upconverter: state encoding, NCO table
// geometry and the elaboration-time helpers for frequency word, output
// scaling shift and saturation limits.
package iq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Quarter-wave table: 2^QW_BITS entries, addressed together with two
  // quadrant bits taken from the top of the phase accumulator.
  localparam int QW_BITS     = 8;
  localparam int PH_IDX_BITS = QW_BITS + 2;

  // round(2^ph_width * freq / fs), done in integer arithmetic.
  function automatic logic [63:0] calc_freq_word(input int ph_width,
                                                 input int freq_mhz,
                                                 input int fs_mhz);
    logic [63:0] num;
    num = (64'd1 << ph_width) * 64'(freq_mhz);
    return (num + 64'(fs_mhz / 2)) / 64'(fs_mhz);
  endfunction

  // Right shift that brings the full-precision mixer sum to the output width.
  function automatic int calc_shift(input int in_w, input int sine_w, input int out_w);
    return in_w + sine_w - out_w - 1;
  endfunction

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/iq_nco.sv
// Numerically controlled oscillator: phase accumulator plus a quarter-wave
// sine table. cos/sin for the phase held in a given cycle appear two clocks
// later, both taken from the same accumulator value.
module iq_nco
  import iq_pkg::*;
#(
  parameter int                  PH_WIDTH   = 32,
  parameter int                  SINE_WIDTH = 13,
  parameter logic [PH_WIDTH-1:0] FREQ_WORD  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  output logic signed [SINE_WIDTH-1:0] cos_out,
  output logic signed [SINE_WIDTH-1:0] sin_out
);

  localparam int  MAG_W   = SINE_WIDTH - 1;
  localparam int  QW_SIZE = 1 << QW_BITS;
  localparam real PI      = 3.141592653589793;
  localparam real AMP     = real'((1 << MAG_W) - 1);
  localparam logic [MAG_W-1:0] AMP_MAG = MAG_W'((1 << MAG_W) - 1);

  logic [PH_WIDTH-1:0]    ph;
  logic [PH_IDX_BITS-1:0] ph_idx;
  logic [1:0]             quad;
  logic [QW_BITS-1:0]     k;
  logic [QW_BITS-1:0]     k_mir;
  logic [MAG_W-1:0]       mag_dir;
  logic [MAG_W-1:0]       mag_mir;
  logic [MAG_W-1:0]       qw_lut [QW_SIZE];

  logic [MAG_W-1:0] sin_mag_r;
  logic [MAG_W-1:0] cos_mag_r;
  logic             sin_neg_r;
  logic             cos_neg_r;

  // Entry k holds round(AMP*sin(2*pi*k/(4*QW_SIZE))), fixed at elaboration.
  for (genvar g = 0; g < QW_SIZE; g++) begin : g_lut
    localparam real ANGLE = 2.0 * PI * real'(g) / real'(4 * QW_SIZE);
    assign qw_lut[g] = MAG_W'($rtoi(AMP * $sin(ANGLE) + 0.5));
  end

  assign ph_idx  = ph[PH_WIDTH-1 -: PH_IDX_BITS];
  assign quad    = ph_idx[PH_IDX_BITS-1 -: 2];
  assign k       = ph_idx[QW_BITS-1:0];
  assign k_mir   = ~k + QW_BITS'(1);
  assign mag_dir = qw_lut[k];
  // The mirrored lookup at k=0 would need entry QW_SIZE (the peak), which the
  // table does not hold, so the peak is substituted directly.
  assign mag_mir = (k == '0) ? AMP_MAG : qw_lut[k_mir];

  // Phase accumulator: held at zero while idle so a run starts at phase 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      ph <= '0;
    else if (!run) ph <= '0;
    else           ph <= ph + FREQ_WORD;
  end

  // Stage 1: table magnitude and sign per quadrant; cos is sin a quadrant ahead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sin_mag_r <= '0;
      cos_mag_r <= '0;
      sin_neg_r <= 1'b0;
      cos_neg_r <= 1'b0;
    end else if (!run) begin
      sin_mag_r <= '0;
      cos_mag_r <= '0;
      sin_neg_r <= 1'b0;
      cos_neg_r <= 1'b0;
    end else begin
      sin_mag_r <= quad[0] ? mag_mir : mag_dir;
      cos_mag_r <= quad[0] ? mag_dir : mag_mir;
      sin_neg_r <= quad[1];
      cos_neg_r <= quad[1] ^ quad[0];
    end
  end

  // Stage 2: apply the sign to produce two's-complement cos/sin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cos_out <= '0;
      sin_out <= '0;
    end else if (!run) begin
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      cos_out <= cos_neg_r ? -$signed({1'b0, cos_mag_r}) : $signed({1'b0, cos_mag_r});
      sin_out <= sin_neg_r ? -$signed({1'b0, sin_mag_r}) : $signed({1'b0, sin_mag_r});
    end
  end

endmodule

// File: rtl/iq_upconvert.sv
// Quadrature upconverter: zero-order-holds a baseband I/Q sample requested
// once every INTERP clocks, mixes it with the NCO carrier and emits a rounded,
// saturated real band-pass sample every clock.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | tx_en low; datapath cleared, no requests, underrun held
//   ST_RUN  | carrier running, sample_req every INTERP clocks, mixing live
module iq_upconvert
  import iq_pkg::*;
#(
  parameter int IN_WIDTH   = 13,
  parameter int OUT_WIDTH  = 10,
  parameter int SINE_WIDTH = 13,
  parameter int PH_WIDTH   = 32,
  parameter int INTER_FREQ = 2,
  parameter int FS_MHZ     = 36,
  parameter int INTERP     = 20
) (
  input  logic                        clk_36MHz,
  input  logic                        rst,
  input  logic                        tx_en,
  input  logic signed [IN_WIDTH-1:0]  comp_env_I,
  input  logic signed [IN_WIDTH-1:0]  comp_env_Q,
  input  logic                        in_valid,
  output logic                        sample_req,
  output logic signed [OUT_WIDTH-1:0] band_sig_out,
  output logic                        underrun
);

  localparam logic [PH_WIDTH-1:0] FREQ_WORD =
    PH_WIDTH'(calc_freq_word(PH_WIDTH, INTER_FREQ, FS_MHZ));
  localparam int CNT_W  = $clog2(INTERP);
  localparam int PROD_W = IN_WIDTH + SINE_WIDTH;
  localparam int SUM_W  = PROD_W + 1;
  localparam int SHIFT  = calc_shift(IN_WIDTH, SINE_WIDTH, OUT_WIDTH);
  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(INTERP - 1);
  localparam logic signed [SUM_W-1:0] ROUND_BIAS = SUM_W'(1 << (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] SAT_HI     = SUM_W'(sat_max(OUT_WIDTH));
  localparam logic signed [SUM_W-1:0] SAT_LO     = SUM_W'(sat_min(OUT_WIDTH));

  state_t state;
  state_t next_state;
  logic   run;

  logic [CNT_W-1:0]           cnt;
  logic signed [IN_WIDTH-1:0] hold_i;
  logic signed [IN_WIDTH-1:0] hold_q;
  logic                       seen_valid;
  logic                       first_req;

  logic signed [SINE_WIDTH-1:0] cos_v;
  logic signed [SINE_WIDTH-1:0] sin_v;
  logic signed [PROD_W-1:0]     prod_i;
  logic signed [PROD_W-1:0]     prod_q;
  logic signed [SUM_W-1:0]      sum_r;
  logic signed [SUM_W-1:0]      rounded;
  logic signed [SUM_W-1:0]      shifted;
  logic signed [OUT_WIDTH-1:0]  sat_val;

  // Datapath registers advance only while running and still enabled, so the
  // clock that drops tx_en already clears them.
  assign run = (state == ST_RUN) && tx_en;

  // State register.
  always_ff @(posedge clk_36MHz or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next state and the request strobe (first RUN cycle has cnt=0).
  always_comb begin
    next_state = state;
    sample_req = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_en) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (!tx_en) next_state = ST_IDLE;
        sample_req = (cnt == '0);
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Sample-period counter, 0..INTERP-1.
  always_ff @(posedge clk_36MHz or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (!run)            cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + CNT_W'(1);
  end

  // Zero-order hold of the baseband sample; every strobe loads, last wins.
  always_ff @(posedge clk_36MHz or negedge rst) begin
    if (!rst) begin
      hold_i <= '0;
      hold_q <= '0;
    end else if (!run) begin
      hold_i <= '0;
      hold_q <= '0;
    end else if (in_valid) begin
      hold_i <= comp_env_I;
      hold_q <= comp_env_Q;
    end
  end

  // Underrun tracking: a strobe coincident with a request belongs to the new
  // period, and the first request of a run has no previous period to judge.
  always_ff @(posedge clk_36MHz or negedge rst) begin
    if (!rst) begin
      underrun   <= 1'b0;
      seen_valid <= 1'b0;
      first_req  <= 1'b1;
    end else if (!run) begin
      seen_valid <= 1'b0;
      first_req  <= 1'b1;
    end else if (sample_req) begin
      if (!first_req && !seen_valid) underrun <= 1'b1;
      seen_valid <= in_valid;
      first_req  <= 1'b0;
    end else if (in_valid) begin
      seen_valid <= 1'b1;
    end
  end

  iq_nco #(
    .PH_WIDTH   (PH_WIDTH),
    .SINE_WIDTH (SINE_WIDTH),
    .FREQ_WORD  (FREQ_WORD)
  ) u_nco (
    .clk     (clk_36MHz),
    .rst     (rst),
    .run     (run),
    .cos_out (cos_v),
    .sin_out (sin_v)
  );

  // Round half-up, arithmetic shift, clamp to the output range.
  always_comb begin
    rounded = sum_r + ROUND_BIAS;
    shifted = rounded >>> SHIFT;
    if (shifted > SAT_HI)      sat_val = SAT_HI[OUT_WIDTH-1:0];
    else if (shifted < SAT_LO) sat_val = SAT_LO[OUT_WIDTH-1:0];
    else                       sat_val = shifted[OUT_WIDTH-1:0];
  end

  // Mixer pipeline: products, difference, scaled output (hold -> out = 3 clocks).
  always_ff @(posedge clk_36MHz or negedge rst) begin
    if (!rst) begin
      prod_i       <= '0;
      prod_q       <= '0;
      sum_r        <= '0;
      band_sig_out <= '0;
    end else if (!run) begin
      prod_i       <= '0;
      prod_q       <= '0;
      sum_r        <= '0;
      band_sig_out <= '0;
    end else begin
      prod_i       <= PROD_W'(hold_i) * PROD_W'(cos_v);
      prod_q       <= PROD_W'(hold_q) * PROD_W'(sin_v);
      sum_r        <= SUM_W'(prod_i) - SUM_W'(prod_q);
      band_sig_out <= sat_val;
    end
  end

endmodule

// File: tb/tb_iq_upconvert.sv
// Directed bench for iq_upconvert. Cycle 0 is the first RUN cycle; the output
// in cycle m carries the carrier phase of RUN cycle m-5.
module tb_iq_upconvert;

  logic              clk_36MHz = 1'b0;
  logic              rst = 1'b1;
  logic              tx_en = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [12:0] comp_env_I = '0;
  logic signed [12:0] comp_env_Q = '0;
  logic              sample_req;
  logic signed [9:0] band_sig_out;
  logic              underrun;

  int checks = 0;
  int errors = 0;

  iq_upconvert dut (
    .clk_36MHz    (clk_36MHz),
    .rst          (rst),
    .tx_en        (tx_en),
    .comp_env_I   (comp_env_I),
    .comp_env_Q   (comp_env_Q),
    .in_valid     (in_valid),
    .sample_req   (sample_req),
    .band_sig_out (band_sig_out),
    .underrun     (underrun)
  );

  always #5 clk_36MHz = ~clk_36MHz;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_36MHz);
    #1;
  endtask

  // Leaves the bench one step after the first RUN edge (cycle 0).
  task automatic start_run();
    tx_en    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    tx_en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (band_sig_out !== 10'sd0 || sample_req !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out=%0d req=%b underrun=%b, required 0 0 0",
               band_sig_out, sample_req, underrun);
    end
    tx_en = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (sample_req !== 1'b0 || band_sig_out !== 10'sd0) begin
      errors++;
      $display("FAIL reset_hold: req=%b out=%0d while rst low, required 0 0",
               sample_req, band_sig_out);
    end
    tx_en = 1'b0;
    rst   = 1'b1;
    tick();
  endtask

  // I=4095, Q=0 answered in the request cycle itself.
  task automatic test_tone(input string tag);
    logic signed [9:0] seen [48];
    int idx   [7] = '{4, 5, 6, 11, 14, 23, 24};
    int exp_v [7] = '{0, 511, 482, -255, -512, 511, 482};
    start_run();
    for (int c = 0; c < 48; c++) begin
      seen[c] = band_sig_out;
      if (c == 0) begin
        checks++;
        if (sample_req !== 1'b1) begin
          errors++;
          $display("FAIL %s first_req: got %b required 1", tag, sample_req);
        end
      end
      in_valid   = sample_req;
      comp_env_I = 13'sd4095;
      comp_env_Q = 13'sd0;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (int'(seen[idx[i]]) !== exp_v[i]) begin
        errors++;
        $display("FAIL %s out cycle %0d: got %0d required %0d",
                 tag, idx[i], seen[idx[i]], exp_v[i]);
      end
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL %s underrun: got %b required 0", tag, underrun);
    end
  endtask

  task automatic test_quadrature();
    logic signed [9:0] seen [30];
    int idx   [5] = '{5, 6, 14, 23, 24};
    int exp_v [5] = '{0, -86, -2, 2, -86};
    start_run();
    for (int c = 0; c < 30; c++) begin
      seen[c]    = band_sig_out;
      in_valid   = sample_req;
      comp_env_I = 13'sd0;
      comp_env_Q = 13'sd2048;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (int'(seen[idx[i]]) !== exp_v[i]) begin
        errors++;
        $display("FAIL quadrature out cycle %0d: got %0d required %0d",
                 idx[i], seen[idx[i]], exp_v[i]);
      end
    end
  endtask

  // Two strobes in one period: the second must replace the first.
  task automatic test_last_wins();
    logic signed [9:0] seen [10];
    start_run();
    for (int c = 0; c < 10; c++) begin
      seen[c]    = band_sig_out;
      in_valid   = (c == 0) || (c == 1);
      comp_env_I = (c == 0) ? 13'sd1000 : 13'sd4095;
      comp_env_Q = 13'sd0;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (seen[5] !== 10'sd511) begin
      errors++;
      $display("FAIL last_wins out cycle 5: got %0d required 511", seen[5]);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL last_wins underrun: got %b required 0", underrun);
    end
  endtask

  // 1000 periods, each request answered three clocks later.
  task automatic test_cadence();
    int bad   = 0;
    int reqs  = 0;
    int since = -1;
    start_run();
    for (int c = 0; c < 20000; c++) begin
      if (sample_req !== ((c % 20) == 0)) bad++;
      if (sample_req === 1'b1) begin
        reqs++;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
      in_valid   = (since == 3);
      comp_env_I = 13'sd1000;
      comp_env_Q = -13'sd500;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL cadence: %0d cycles with wrong sample_req, required 0", bad);
    end
    checks++;
    if (reqs !== 1000) begin
      errors++;
      $display("FAIL cadence_count: got %0d requests required 1000", reqs);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL cadence_underrun: got %b required 0", underrun);
    end
  endtask

  task automatic test_enable_drop();
    int bad_out = 0;
    int bad_req = 0;
    logic signed [9:0] pre = '0;
    start_run();
    for (int c = 0; c < 80; c++) begin
      if (c == 23) pre = band_sig_out;
      if (c >= 34 && band_sig_out !== 10'sd0) bad_out++;
      if (c >= 31 && sample_req !== 1'b0) bad_req++;
      if (c == 30) tx_en = 1'b0;
      in_valid   = (c < 30) && sample_req;
      comp_env_I = 13'sd4095;
      comp_env_Q = 13'sd0;
      tick();
    end
    checks++;
    if (pre !== 10'sd511) begin
      errors++;
      $display("FAIL enable_pre out cycle 23: got %0d required 511", pre);
    end
    checks++;
    if (bad_out !== 0) begin
      errors++;
      $display("FAIL enable_drop_out: %0d nonzero samples after drop, required 0", bad_out);
    end
    checks++;
    if (bad_req !== 0) begin
      errors++;
      $display("FAIL enable_drop_req: %0d requests after drop, required 0", bad_req);
    end
  endtask

  // No strobe in the period starting at cycle 20.
  task automatic test_starvation();
    start_run();
    for (int c = 0; c < 100; c++) begin
      if (c == 40) begin
        checks++;
        if (underrun !== 1'b0) begin
          errors++;
          $display("FAIL starve_early: underrun %b at cycle 40 required 0", underrun);
        end
      end
      if (c == 41) begin
        checks++;
        if (underrun !== 1'b1) begin
          errors++;
          $display("FAIL starve_set: underrun %b at cycle 41 required 1", underrun);
        end
        checks++;
        if (band_sig_out !== 10'sd511) begin
          errors++;
          $display("FAIL starve_hold out cycle 41: got %0d required 511", band_sig_out);
        end
      end
      in_valid   = sample_req && (c != 20);
      comp_env_I = 13'sd4095;
      comp_env_Q = 13'sd0;
      tick();
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL starve_sticky: underrun %b required 1", underrun);
    end
    tx_en    = 1'b0;
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (underrun !== 1'b1 || band_sig_out !== 10'sd0) begin
      errors++;
      $display("FAIL starve_idle: underrun=%b out=%0d required 1 0", underrun, band_sig_out);
    end
  endtask

  task automatic test_reset_restart();
    start_run();
    for (int c = 0; c < 12; c++) begin
      in_valid   = sample_req;
      comp_env_I = 13'sd4095;
      comp_env_Q = 13'sd0;
      tick();
    end
    #2 rst = 1'b0;
    tx_en    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (band_sig_out !== 10'sd0 || sample_req !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out=%0d req=%b underrun=%b required 0 0 0",
               band_sig_out, sample_req, underrun);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    test_tone("restart");
  endtask

  initial begin
    test_reset();
    test_tone("tone");
    test_quadrature();
    test_last_wins();
    test_cadence();
    test_enable_drop();
    test_starvation();
    test_reset_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
